// File: rtl/serial_subtractor_32bits.sv
// Bit-serial two's-complement subtractor: a - b computed LSB first through one
// full-adder slice as a + ~b + 1, with start/busy/done handshake and ALU flags.
module serial_subtractor_32bits #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] SIGN_IN  = CNT_W'(WIDTH - 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             c;
  logic             c30;
  logic [CNT_W-1:0] cnt;

  logic             d;
  logic             c_next;
  logic [WIDTH-1:0] res_full;

  // Full-adder slice on the current LSBs; res_full is the result including this bit.
  assign d        = a_sh[0] ^ b_sh[0] ^ c;
  assign c_next   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
  assign res_full = {d, res_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      c         <= 1'b0;
      c30       <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      s         <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= ~b;
            c      <= 1'b1;  // the +1 of the two's-complement negation of b
            cnt    <= '0;
            res_sh <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_full;
          c      <= c_next;
          cnt    <= cnt + 1'b1;
          if (cnt == SIGN_IN) begin
            c30 <= c_next;
          end
          if (cnt == LAST_BIT) begin
            s         <= res_full;
            carry_out <= c_next;
            overflow  <= c30 ^ c_next;
            zero      <= (res_full == '0);
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
